// File: rtl/stage_id_pkg.sv
// -----------------------------------------------------------------------------
// stage_id_pkg
// Shared MIPS decode definitions for the instruction-decode stage:
//   - datapath / register-file sizing defaults (DATA_W, REG_N, REG_W)
//   - opcode and R-type funct constants
//   - ALU operation encodings
//   - the ID/EX pipeline register record
//   - imm16 sign-extension helper
// No ports (package).
// -----------------------------------------------------------------------------
package stage_id_pkg;

  localparam int DATA_W = 32;
  localparam int REG_N  = 32;
  localparam int REG_W  = $clog2(REG_N);

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4
  } alu_op_e;

  // Everything handed to EX; an all-zero record is a bubble.
  typedef struct packed {
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    alu_op_e           alu_op;
    logic              alu_src;
    logic              reg_dst;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
  } id_ex_t;

  function automatic logic [DATA_W-1:0] sign_ext16(input logic [15:0] imm16);
    sign_ext16 = {{(DATA_W-16){imm16[15]}}, imm16};
  endfunction

endpackage

// File: rtl/stage_id_if.sv
// -----------------------------------------------------------------------------
// stage_id_if
// Bundles every non-clock/reset signal of the decode stage.
//   slave  : the decode stage (consumes fetch/WB/EX info, produces ID/EX + redirect)
//   master : the surrounding pipeline (fetch, write-back, EX) or a testbench
// Signals:
//   instruction, data_npc           fetch -> ID
//   wb_we, wb_reg, wb_data          write-back port into the register file
//   ex_mem_read, ex_rt              load currently in EX (hazard detection)
//   control_use_npc, data_jump_address, stall   combinational ID -> fetch
//   id_*                            registered ID/EX outputs
// -----------------------------------------------------------------------------
interface stage_id_if;
  import stage_id_pkg::*;

  logic [DATA_W-1:0] instruction;
  logic [DATA_W-1:0] data_npc;
  logic              wb_we;
  logic [REG_W-1:0]  wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic              ex_mem_read;
  logic [REG_W-1:0]  ex_rt;

  logic              control_use_npc;
  logic [DATA_W-1:0] data_jump_address;
  logic              stall;

  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic [REG_W-1:0]  id_rs;
  logic [REG_W-1:0]  id_rt;
  logic [REG_W-1:0]  id_rd;
  logic [3:0]        id_alu_op;
  logic              id_alu_src;
  logic              id_reg_dst;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              id_mem_write;

  modport slave (
    input  instruction, data_npc, wb_we, wb_reg, wb_data, ex_mem_read, ex_rt,
    output control_use_npc, data_jump_address, stall,
    output id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd, id_alu_op,
    output id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write
  );

  modport master (
    output instruction, data_npc, wb_we, wb_reg, wb_data, ex_mem_read, ex_rt,
    input  control_use_npc, data_jump_address, stall,
    input  id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd, id_alu_op,
    input  id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write
  );
endinterface

// File: rtl/stage_id_register_file.sv
// -----------------------------------------------------------------------------
// stage_id_register_file
// REG_N x DATA_W architectural register file.
//   clock, reset (async active-low, clears all registers)
//   we/waddr/wdata        : synchronous write port (writes to r0 ignored)
//   raddr_a/rdata_a,
//   raddr_b/rdata_b       : asynchronous read ports; r0 reads 0 and a
//                           same-cycle write to the read index is forwarded
// -----------------------------------------------------------------------------
module stage_id_register_file #(
  parameter int DATA_W = 32,
  parameter int REG_N  = 32,
  localparam int REG_W = $clog2(REG_N)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [REG_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_W-1:0]  raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [REG_W-1:0]  raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs_q [REG_N];
  logic [DATA_W-1:0] regs_d [REG_N];

  // Next register-file contents: apply the write-back unless it targets r0.
  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != '0)) begin
      regs_d[waddr] = wdata;
    end else begin
      regs_d = regs_q;
    end
  end

  // Register storage, cleared on reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_N; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read port A: r0 hardwired, then write-back bypass, then storage.
  always_comb begin
    rdata_a = '0;
    if (raddr_a == '0) begin
      rdata_a = '0;
    end else if (we && (waddr == raddr_a)) begin
      rdata_a = wdata;
    end else begin
      rdata_a = regs_q[raddr_a];
    end
  end

  // Read port B: same priority as port A.
  always_comb begin
    rdata_b = '0;
    if (raddr_b == '0) begin
      rdata_b = '0;
    end else if (we && (waddr == raddr_b)) begin
      rdata_b = wdata;
    end else begin
      rdata_b = regs_q[raddr_b];
    end
  end

endmodule

// File: rtl/stage_id.sv
// -----------------------------------------------------------------------------
// stage_id
// MIPS instruction-decode stage.
//   clock : rising-edge system clock
//   reset : asynchronous active-low reset
//   bus   : stage_id_if.slave (fetch inputs, write-back, EX load info,
//           redirect/stall back to fetch, registered ID/EX outputs)
// Reads/writes the register file, decodes control, resolves branches and
// jumps in ID, detects load-use hazards and registers the ID/EX record.
// Build option STAGE_ID_DELAY_SLOT_EN: when defined, the instruction after a
// taken branch/jump executes (branch delay slot) and no flush is generated;
// when undefined, that instruction is squashed into a bubble.
// -----------------------------------------------------------------------------
module stage_id
  import stage_id_pkg::*;
#(
  parameter int DATA_W_P = DATA_W,
  parameter int REG_N_P  = REG_N
) (
  input  logic      clock,
  input  logic      reset,
  stage_id_if.slave bus
);

  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [REG_W-1:0]  rs_idx;
  logic [REG_W-1:0]  rt_idx;
  logic [REG_W-1:0]  rd_idx;
  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;

  logic    valid;
  logic    is_beq;
  logic    is_bne;
  logic    is_j;
  logic    uses_rt;
  alu_op_e alu_op;
  logic    alu_src;
  logic    reg_dst;
  logic    reg_write;
  logic    mem_read;
  logic    mem_write;

  logic    stall_s;
  logic    taken_s;
  logic    bubble_s;
  logic [DATA_W-1:0] jump_addr_s;

  logic    flush_d, flush_q;
  id_ex_t  id_ex_d, id_ex_q;

  assign opcode   = bus.instruction[31:26];
  assign rs_idx   = bus.instruction[25:21];
  assign rt_idx   = bus.instruction[20:16];
  assign rd_idx   = bus.instruction[15:11];
  assign funct    = bus.instruction[5:0];
  assign imm_sext = sign_ext16(bus.instruction[15:0]);

  stage_id_register_file #(
    .DATA_W (DATA_W_P),
    .REG_N  (REG_N_P)
  ) u_register_file (
    .clock   (clock),
    .reset   (reset),
    .we      (bus.wb_we),
    .waddr   (bus.wb_reg),
    .wdata   (bus.wb_data),
    .raddr_a (rs_idx),
    .rdata_a (rs_data),
    .raddr_b (rt_idx),
    .rdata_b (rt_data)
  );

  // Opcode/funct decode into control bits; anything unrecognised is invalid.
  always_comb begin
    valid     = 1'b0;
    is_beq    = 1'b0;
    is_bne    = 1'b0;
    is_j      = 1'b0;
    uses_rt   = 1'b0;
    alu_op    = ALU_ADD;
    alu_src   = 1'b0;
    reg_dst   = 1'b0;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        valid     = 1'b1;
        uses_rt   = 1'b1;
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          default: valid  = 1'b0;
        endcase
      end
      OP_ADDI: begin
        valid     = 1'b1;
        alu_src   = 1'b1;
        reg_write = 1'b1;
      end
      OP_LW: begin
        valid     = 1'b1;
        alu_src   = 1'b1;
        reg_write = 1'b1;
        mem_read  = 1'b1;
      end
      OP_SW: begin
        valid     = 1'b1;
        uses_rt   = 1'b1;
        alu_src   = 1'b1;
        mem_write = 1'b1;
      end
      OP_BEQ: begin
        valid   = 1'b1;
        is_beq  = 1'b1;
        uses_rt = 1'b1;
        alu_op  = ALU_SUB;
      end
      OP_BNE: begin
        valid   = 1'b1;
        is_bne  = 1'b1;
        uses_rt = 1'b1;
        alu_op  = ALU_SUB;
      end
      OP_J: begin
        valid = 1'b1;
        is_j  = 1'b1;
      end
      default: valid = 1'b0;
    endcase
  end

  // Hazard, redirect and flush. A flushed instruction can neither stall nor
  // redirect, and everything combinational is held low while in reset.
  always_comb begin
    stall_s = reset && !flush_q && valid && bus.ex_mem_read &&
              (bus.ex_rt != '0) &&
              ((!is_j && (bus.ex_rt == rs_idx)) ||
               (uses_rt && (bus.ex_rt == rt_idx)));
    taken_s = reset && !flush_q && !stall_s &&
              ((is_beq && (rs_data == rt_data)) ||
               (is_bne && (rs_data != rt_data)) ||
               is_j);
    jump_addr_s = is_j ? {bus.data_npc[31:28], bus.instruction[25:0], 2'b00}
                       : (bus.data_npc + {imm_sext[DATA_W-3:0], 2'b00});
    bubble_s = !valid || stall_s || flush_q;
`ifdef STAGE_ID_DELAY_SLOT_EN
    flush_d = 1'b0;
`else
    flush_d = taken_s;
`endif
  end

  // Next ID/EX record: decoded instruction, or all zeros for a bubble.
  always_comb begin
    id_ex_d = '0;
    if (!bubble_s) begin
      id_ex_d.rs_data   = rs_data;
      id_ex_d.rt_data   = rt_data;
      id_ex_d.imm       = imm_sext;
      id_ex_d.rs        = rs_idx;
      id_ex_d.rt        = rt_idx;
      id_ex_d.rd        = rd_idx;
      id_ex_d.alu_op    = alu_op;
      id_ex_d.alu_src   = alu_src;
      id_ex_d.reg_dst   = reg_dst;
      id_ex_d.reg_write = reg_write;
      id_ex_d.mem_read  = mem_read;
      id_ex_d.mem_write = mem_write;
    end else begin
      id_ex_d = '0;
    end
  end

  // ID/EX pipeline register and flush flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      id_ex_q <= '0;
      flush_q <= 1'b0;
    end else begin
      id_ex_q <= id_ex_d;
      flush_q <= flush_d;
    end
  end

  assign bus.control_use_npc   = taken_s;
  assign bus.data_jump_address = jump_addr_s;
  assign bus.stall             = stall_s;
  assign bus.id_rs_data        = id_ex_q.rs_data;
  assign bus.id_rt_data        = id_ex_q.rt_data;
  assign bus.id_imm            = id_ex_q.imm;
  assign bus.id_rs             = id_ex_q.rs;
  assign bus.id_rt             = id_ex_q.rt;
  assign bus.id_rd             = id_ex_q.rd;
  assign bus.id_alu_op         = id_ex_q.alu_op;
  assign bus.id_alu_src        = id_ex_q.alu_src;
  assign bus.id_reg_dst        = id_ex_q.reg_dst;
  assign bus.id_reg_write      = id_ex_q.reg_write;
  assign bus.id_mem_read       = id_ex_q.mem_read;
  assign bus.id_mem_write      = id_ex_q.mem_write;

endmodule

// File: tb/tb_stage_id.sv
// -----------------------------------------------------------------------------
// tb_stage_id
// Directed self-checking bench for stage_id. Inputs change 1 time unit after
// a rising edge; combinational outputs are checked on the falling edge and
// registered outputs 1 time unit after the following rising edge.
// -----------------------------------------------------------------------------
module tb_stage_id;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  stage_id_if bus ();

  stage_id dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] npc,
                       input logic we, input logic [4:0] wreg, input logic [31:0] wdata,
                       input logic exmr, input logic [4:0] exrt);
    bus.instruction = instr;
    bus.data_npc    = npc;
    bus.wb_we       = we;
    bus.wb_reg      = wreg;
    bus.wb_data     = wdata;
    bus.ex_mem_read = exmr;
    bus.ex_rt       = exrt;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    drive(32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    #3;
    chk("rst_rs_data", bus.id_rs_data, 32'h0);
    chk("rst_reg_write", 32'(bus.id_reg_write), 32'h0);
    chk("rst_stall", 32'(bus.stall), 32'h0);
    chk("rst_use_npc", 32'(bus.control_use_npc), 32'h0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;

    // Preload r1=5, r2=7 via write-back
    drive(32'h0, 32'h0, 1'b1, 5'd1, 32'd5, 1'b0, 5'd0);
    tick();
    drive(32'h0, 32'h0, 1'b1, 5'd2, 32'd7, 1'b0, 5'd0);
    tick();

    // add $3,$1,$2
    drive(32'h00221820, 32'h4, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    @(negedge clock);
    chk("add_stall", 32'(bus.stall), 32'h0);
    chk("add_use_npc", 32'(bus.control_use_npc), 32'h0);
    tick();
    chk("add_rs_data", bus.id_rs_data, 32'd5);
    chk("add_rt_data", bus.id_rt_data, 32'd7);
    chk("add_rd", 32'(bus.id_rd), 32'd3);
    chk("add_reg_write", 32'(bus.id_reg_write), 32'h1);
    chk("add_reg_dst", 32'(bus.id_reg_dst), 32'h1);
    chk("add_alu_op", 32'(bus.id_alu_op), 32'd0);

    // Write bypass: r1 <= 0xAA while add reads $1
    drive(32'h00221820, 32'h4, 1'b1, 5'd1, 32'hAA, 1'b0, 5'd0);
    tick();
    chk("byp_rs_data", bus.id_rs_data, 32'hAA);
    chk("byp_rt_data", bus.id_rt_data, 32'd7);

    // Write to r0 while reading $0, then read $0 again
    drive(32'h00021820, 32'h4, 1'b1, 5'd0, 32'h55, 1'b0, 5'd0);
    tick();
    chk("r0_byp", bus.id_rs_data, 32'h0);
    drive(32'h00021820, 32'h4, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    tick();
    chk("r0_read", bus.id_rs_data, 32'h0);

    // Unknown funct (0x21) decodes as bubble
    drive(32'h00221821, 32'h4, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    tick();
    chk("badfn_reg_write", 32'(bus.id_reg_write), 32'h0);
    chk("badfn_rs_data", bus.id_rs_data, 32'h0);

    // r1 = r2 = 9
    drive(32'h0, 32'h0, 1'b1, 5'd1, 32'd9, 1'b0, 5'd0);
    tick();
    drive(32'h0, 32'h0, 1'b1, 5'd2, 32'd9, 1'b0, 5'd0);
    tick();

    // beq $1,$2,3 at npc 0x100 -> taken to 0x10C
    drive(32'h10220003, 32'h100, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    @(negedge clock);
    chk("beq_use_npc", 32'(bus.control_use_npc), 32'h1);
    chk("beq_target", bus.data_jump_address, 32'h10C);
    tick();
    chk("beq_imm", bus.id_imm, 32'h3);
    chk("beq_alu_op", 32'(bus.id_alu_op), 32'd1);
    chk("beq_reg_write", 32'(bus.id_reg_write), 32'h0);

    // addi $4,$1,1 right after the taken beq
    drive(32'h20240001, 32'h104, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    tick();
`ifdef STAGE_ID_DELAY_SLOT_EN
    chk("slot_reg_write", 32'(bus.id_reg_write), 32'h1);
    chk("slot_rs_data", bus.id_rs_data, 32'd9);
    chk("slot_imm", bus.id_imm, 32'h1);
`else
    chk("flush_reg_write", 32'(bus.id_reg_write), 32'h0);
    chk("flush_rs_data", bus.id_rs_data, 32'h0);
    chk("flush_imm", bus.id_imm, 32'h0);
`endif

    // bne $1,$3,-1 at npc 0x100: 9 != 0 -> taken to 0x0FC
    drive(32'h1423FFFF, 32'h100, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    @(negedge clock);
    chk("bne_use_npc", 32'(bus.control_use_npc), 32'h1);
    chk("bne_target", bus.data_jump_address, 32'h0FC);
    tick();

    // j 0x40 at npc 0x10000004 immediately after the taken bne
    drive(32'h08000040, 32'h10000004, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    @(negedge clock);
    chk("j_target", bus.data_jump_address, 32'h10000100);
`ifdef STAGE_ID_DELAY_SLOT_EN
    chk("j_slot_use_npc", 32'(bus.control_use_npc), 32'h1);
`else
    chk("j_flushed_use_npc", 32'(bus.control_use_npc), 32'h0);
`endif
    tick();

    // Same jump again; never flushed now
    @(negedge clock);
    chk("j_use_npc", 32'(bus.control_use_npc), 32'h1);
    chk("j_target2", bus.data_jump_address, 32'h10000100);
    tick();

    // sub $5,$4,$6 with load to $4 in EX, right after the taken j
    drive(32'h00862822, 32'h10000104, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4);
    @(negedge clock);
`ifdef STAGE_ID_DELAY_SLOT_EN
    chk("slot_lu_stall", 32'(bus.stall), 32'h1);
`else
    chk("flush_beats_stall", 32'(bus.stall), 32'h0);
`endif
    tick();
    chk("flush_lu_reg_write", 32'(bus.id_reg_write), 32'h0);

    // Load-use stall proper
    @(negedge clock);
    chk("lu_stall", 32'(bus.stall), 32'h1);
    chk("lu_use_npc", 32'(bus.control_use_npc), 32'h0);
    tick();
    chk("lu_bubble", 32'(bus.id_reg_write), 32'h0);
    chk("lu_bubble_rd", 32'(bus.id_rd), 32'h0);

    // Load gone: sub re-presented decodes normally
    drive(32'h00862822, 32'h10000104, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    @(negedge clock);
    chk("lu_release_stall", 32'(bus.stall), 32'h0);
    tick();
    chk("sub_reg_write", 32'(bus.id_reg_write), 32'h1);
    chk("sub_alu_op", 32'(bus.id_alu_op), 32'd1);
    chk("sub_rd", 32'(bus.id_rd), 32'd5);
    chk("sub_rs", 32'(bus.id_rs), 32'd4);
    chk("sub_rt", 32'(bus.id_rt), 32'd6);

    // rt match on R-type stalls
    drive(32'h00862822, 32'h10000104, 1'b0, 5'd0, 32'h0, 1'b1, 5'd6);
    @(negedge clock);
    chk("lu_rt_stall", 32'(bus.stall), 32'h1);
    tick();

    // ex_rt = 0 never stalls: sub $5,$0,$6
    drive(32'h00062822, 32'h10000104, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
    @(negedge clock);
    chk("lu_r0_stall", 32'(bus.stall), 32'h0);
    tick();
    chk("lu_r0_reg_write", 32'(bus.id_reg_write), 32'h1);

    // lw $6,0($1): rt is a destination, not a source -> no stall on ex_rt=6
    drive(32'h8C260000, 32'h10000108, 1'b0, 5'd0, 32'h0, 1'b1, 5'd6);
    @(negedge clock);
    chk("lw_rt_nostall", 32'(bus.stall), 32'h0);
    tick();
    chk("lw_mem_read", 32'(bus.id_mem_read), 32'h1);
    chk("lw_alu_src", 32'(bus.id_alu_src), 32'h1);
    chk("lw_rs_data", bus.id_rs_data, 32'd9);

    // Async reset in the cycle after a taken jump
    drive(32'h08000040, 32'h10000004, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    tick();
    chk("pre_rst_imm", bus.id_imm, 32'h40);
    drive(32'h20240001, 32'h10000104, 1'b0, 5'd0, 32'h0, 1'b1, 5'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_imm", bus.id_imm, 32'h0);
    chk("midrst_stall", 32'(bus.stall), 32'h0);
    chk("midrst_use_npc", 32'(bus.control_use_npc), 32'h0);
    tick();
    chk("inrst_imm", bus.id_imm, 32'h0);
    reset = 1'b1;
    drive(32'h00221820, 32'h4, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    tick();
    chk("postrst_reg_write", 32'(bus.id_reg_write), 32'h1);
    chk("postrst_rd", 32'(bus.id_rd), 32'd3);
    chk("postrst_rs_data", bus.id_rs_data, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
